serial_shift_engine: RTL

Parametrised successor to the 8-bit shift register: a framed, bidirectional serial shifter for the SPI-style peripheral path. The peripheral clock edge is split into separate sample and launch strobes. Each frame selects MSB-first or LSB-first order. A bit counter tracks frame completion and drives busy/done status, and the last received word is held until the next frame completes.

---
 rtl/serial_shift_engine.sv | 122 ++++++++++++
 1 files changed

// File: rtl/serial_shift_engine.sv
// Framed bidirectional serial shifter with split sample/launch strobes and per-frame bit order.
// Optional even-parity output of the received word is built when SERIAL_SHIFT_PARITY_EN is defined.
module serial_shift_engine #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             sampleEdge,
  input  logic             shiftEdge,
  input  logic             parallelLoad,
  input  logic             lsbFirst,
  input  logic [WIDTH-1:0] parallelDataIn,
  input  logic             serialDataIn,
  output logic             serialDataOut,
  output logic [WIDTH-1:0] parallelDataOut,
  output logic             busy,
  output logic             done,
  output logic             loadDropped,
  output logic             parityOut
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} stateT;

  stateT            state, stateNext;
  logic [WIDTH-1:0] shreg, shregNext, shifted;
  logic [CNT_W-1:0] bitCount, bitCountNext;
  logic             sampledBit, sampledBitNext;
  logic             orderReg, orderRegNext;
  logic [WIDTH-1:0] parallelDataOutNext;
  logic             busyNext, doneNext, loadDroppedNext;
  logic             inBit;
`ifdef SERIAL_SHIFT_PARITY_EN
  logic             parityNext;
`endif

  assign serialDataOut = orderReg ? shreg[0] : shreg[WIDTH-1];

  // A same-cycle sample strobe feeds the live input straight into the shift.
  assign inBit   = sampleEdge ? serialDataIn : sampledBit;
  assign shifted = orderReg ? {inBit, shreg[WIDTH-1:1]} : {shreg[WIDTH-2:0], inBit};

  always_comb begin
    stateNext           = state;
    shregNext           = shreg;
    bitCountNext        = bitCount;
    sampledBitNext      = sampledBit;
    orderRegNext        = orderReg;
    parallelDataOutNext = parallelDataOut;
    busyNext            = busy;
    doneNext            = 1'b0;
    loadDroppedNext     = 1'b0;
`ifdef SERIAL_SHIFT_PARITY_EN
    parityNext          = parityOut;
`endif
    case (state)
      IDLE: begin
        if (parallelLoad) begin
          shregNext    = parallelDataIn;
          orderRegNext = lsbFirst;
          bitCountNext = '0;
          busyNext     = 1'b1;
          stateNext    = SHIFT;
        end
      end
      SHIFT: begin
        if (parallelLoad) loadDroppedNext = 1'b1;
        if (sampleEdge) sampledBitNext = serialDataIn;
        if (shiftEdge) begin
          shregNext    = shifted;
          bitCountNext = bitCount + CNT_W'(1);
          if (bitCount == CNT_W'(WIDTH - 1)) begin
            parallelDataOutNext = shifted;
            doneNext            = 1'b1;
            busyNext            = 1'b0;
            bitCountNext        = '0;
            stateNext           = IDLE;
`ifdef SERIAL_SHIFT_PARITY_EN
            parityNext          = ^shifted;
`endif
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state           <= IDLE;
      shreg           <= '0;
      bitCount        <= '0;
      sampledBit      <= 1'b0;
      orderReg        <= 1'b0;
      parallelDataOut <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      loadDropped     <= 1'b0;
    end else begin
      state           <= stateNext;
      shreg           <= shregNext;
      bitCount        <= bitCountNext;
      sampledBit      <= sampledBitNext;
      orderReg        <= orderRegNext;
      parallelDataOut <= parallelDataOutNext;
      busy            <= busyNext;
      done            <= doneNext;
      loadDropped     <= loadDroppedNext;
    end
  end

`ifdef SERIAL_SHIFT_PARITY_EN
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) parityOut <= 1'b0;
    else         parityOut <= parityNext;
  end
`else
  assign parityOut = 1'b0;
`endif

endmodule
